// File: rtl/piso_pkg.sv
// Shared types and default sizing for the PISO transmit scheduler.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } piso_state_e;

    localparam int PISO_DATA_W  = 4;
    localparam int PISO_NUM_REQ = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after i_ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx
);

    logic             w_found;
    logic [PTR_W-1:0] w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_k = PTR_W'((32'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_k]) begin
                w_found      = 1'b1;
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
            end
        end
    end

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin fronted PISO transmitter: framed MSB-first serial stream with source tag.
// Optional trailing even-parity bit when PISO_TX_SCHED_PARITY_EN is defined.
module piso_tx_scheduler
    import piso_pkg::*;
#(
    parameter int DATA_W  = PISO_DATA_W,
    parameter int NUM_REQ = PISO_NUM_REQ
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       ser_data,
    output logic                       ser_valid,
    output logic                       ser_first,
    output logic [$clog2(NUM_REQ)-1:0] ser_src,
    output logic                       busy
);

    localparam int IW    = $clog2(NUM_REQ);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    piso_state_e       r_state;
    piso_state_e       w_next;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic [IW-1:0]     r_src;
    logic [IW-1:0]     r_ptr;
`ifdef PISO_TX_SCHED_PARITY_EN
    logic              r_parity;
`endif

    logic [NUM_REQ-1:0] w_grant;
    logic [IW-1:0]      w_idx;
    logic               w_accept;
    logic [DATA_W-1:0]  w_words [NUM_REQ];
    logic [DATA_W-1:0]  w_word;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign w_words[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (IW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign w_word   = w_words[w_idx];
    assign w_accept = |(req_valid & req_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_SHIFT;
            ST_SHIFT: begin
                if (r_cnt == '0) begin
`ifdef PISO_TX_SCHED_PARITY_EN
                    w_next = ST_PARITY;
`else
                    w_next = ST_IDLE;
`endif
                end
            end
`ifdef PISO_TX_SCHED_PARITY_EN
            ST_PARITY: w_next = ST_IDLE;
`endif
            default:   w_next = ST_IDLE;
        endcase
    end

    // The final shift of a frame leaves the register zero, so ser_data idles low.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_src    <= '0;
            r_ptr    <= '0;
`ifdef PISO_TX_SCHED_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (w_accept) begin
            r_shift  <= w_word;
            r_cnt    <= CNT_W'(DATA_W - 1);
            r_src    <= w_idx;
            r_ptr    <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
`ifdef PISO_TX_SCHED_PARITY_EN
            r_parity <= ^w_word;
`endif
        end else if (r_state == ST_SHIFT) begin
            r_shift  <= r_shift << 1;
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE && !reset) ? w_grant : '0;
        ser_valid = (r_state != ST_IDLE);
        busy      = (r_state != ST_IDLE);
        ser_first = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(DATA_W - 1));
        ser_data  = r_shift[DATA_W-1];
`ifdef PISO_TX_SCHED_PARITY_EN
        if (r_state == ST_PARITY) ser_data = r_parity;
`endif
    end

    assign ser_src = r_src;

endmodule

// File: doc/piso_tx_scheduler.md
# piso_tx_scheduler

Arbitrated front end for the 4-bit parallel-in/serial-out shift path. Accepts parallel words from NUM_REQ requesters over valid/ready handshakes and picks one per frame round-robin. Sequences the shift register's load/shift controls and emits a framed, MSB-first serial stream with source tagging.

## Interface
- DATA_W, default 4: word width, which is also the serial bits per frame.
- NUM_REQ, default 2: number of requesters, 2..8.
- clock  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester word available.
- req_data  input  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant/accept; a word transfers when req_valid[i] and req_ready[i] are both high.
- ser_data  output  1  serial bit, registered.
- ser_valid  output  1  ser_data carries a frame bit.
- ser_first  output  1  high on the first (MSB) bit of a frame.
- ser_src  output  $clog2(NUM_REQ)  requester index of the current frame; held until the next frame.
- busy  output  1  frame in progress; high in any state other than IDLE.

## Operation
- FSM states: IDLE, SHIFT, and PARITY (PARITY only when the macro is enabled).
- IDLE:
  - Round-robin arbiter scans req_valid starting at pointer rr_ptr.
  - req_ready is driven combinationally, one-hot on the first valid requester found. It is all-zero if none is valid.
  - On handshake: load req_data[grant] into the internal shift register, set bit counter = DATA_W-1, latch ser_src = grant, set rr_ptr = (grant+1) mod NUM_REQ, then go to SHIFT.
- SHIFT:
  - Each cycle, ser_data = shift register MSB and ser_valid = 1.
  - ser_first = 1 only on the first SHIFT cycle.
  - Register shifts left with zero fill; counter decrements.
  - When counter = 0: go to PARITY if enabled, else IDLE.
- req_ready is 0 in every state except IDLE. Requesters must hold req_valid and req_data stable until accepted.
- Requesters not granted are not starved: with all valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- req_valid dropping while not ready is legal and is simply not granted.
- Reset values: req_ready=0, ser_data=0, ser_valid=0, ser_first=0, ser_src=0, busy=0, rr_ptr=0, FSM=IDLE, shift register=0.
- Reset mid-frame: the frame is aborted. All outputs take reset values on the next edge, and no further bits of that frame are emitted.

## Timing
- Handshake at edge N: the MSB appears on ser_data in cycle N+1. Bit k (MSB=0) appears in cycle N+1+k.
- Frame length is DATA_W cycles, plus 1 with parity.
- One mandatory IDLE cycle between frames, so back-to-back throughput is one frame per DATA_W+1 cycles (DATA_W+2 with parity).
- busy rises in cycle N+1 and falls in the cycle after the last frame bit.
- Grant is decided combinationally in the IDLE cycle. It has zero-cycle accept latency when a requester is already valid.

## Configuration
- PISO_TX_SCHED_PARITY_EN defined:
  - After the last data bit, one PARITY cycle drives ser_data = even parity (XOR of the accepted word), with ser_valid=1 and ser_first=0.
  - FSM then returns to IDLE.
- PISO_TX_SCHED_PARITY_EN undefined: no PARITY state; SHIFT goes directly to IDLE.

## Structure
- Shared package piso_pkg holds:
  - the FSM state enum (ST_IDLE, ST_SHIFT, ST_PARITY);
  - default constants PISO_DATA_W=4 and PISO_NUM_REQ=2.
- Sub-module rr_arbiter is natural. It is combinational one-hot grant from req and rr_ptr, and is instantiated once.
- The shift register, counter and FSM live in the top module.

## Test plan
- Reset, then req_valid=01, req_data[0]=4'b1011 -> req_ready=01 same cycle; ser_data 1,0,1,1 on the next 4 cycles; ser_first only on the first; ser_src=0; then busy=0.
- Both valid continuously with words 4'hA (req 0) and 4'h5 (req 1) -> frames alternate src 0,1,0. Bits are 1010 then 0101, each frame separated by exactly one idle cycle.
- req_valid=10 while a frame from 0 is in SHIFT -> req_ready stays 00 until IDLE, then grants 1.
- reset asserted on the 2nd SHIFT cycle -> next edge all outputs 0, no remaining bits. A new request afterward starts from rr_ptr=0.
- With PISO_TX_SCHED_PARITY_EN, word 4'b0111 -> bits 0,1,1,1 then parity 1 with ser_valid=1. Word 4'b0011 -> parity 0.
- No requests for 20 cycles after reset -> ser_valid, busy and req_ready remain 0.
